// File: rtl/winner_banner.sv
// End-of-round winner screen: latches the first win pulse and draws id+1 vertical bars until ack or timeout.
// Optional glyph blinking is compiled in when WINNER_BANNER_BLINK_EN is defined.
module winner_banner #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int NUM_PLAYERS = 2,
  parameter int HOLD_TICKS  = 600,
  parameter int BLINK_TICKS = 30,
  localparam int ID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_PLAYERS-1:0]     win,
  input  logic                       ack,
  output logic [ROWS-1:0][COLS-1:0]  RedPixels,
  output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
  output logic                       active,
  output logic [ID_W-1:0]            winner_id
);

  localparam int HC_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [COLS-1:0] BAR = COLS'(3);

  typedef enum logic {S_IDLE, S_SHOW} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   winner_id_q, winner_id_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              active_q, active_d;
  logic [COLS-1:0]   glyph_row, grn_row, red_row;
  logic              show_px;

`ifdef WINNER_BANNER_BLINK_EN
  localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
  logic              phase_q, phase_d;
  logic [BC_W-1:0]   blink_cnt_q, blink_cnt_d;
`endif

  // Glyph for a winner: n=id+1 two-column bars on a 4-column pitch, centred.
  function automatic logic [COLS-1:0] make_glyph(input logic [ID_W-1:0] id);
    int n;
    int off;
    make_glyph = '0;
    n   = int'(id) + 1;
    off = (COLS - (4 * n - 2)) / 2;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (k < n) make_glyph = make_glyph | (BAR << (off + 4 * k));
    end
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    winner_id_d = winner_id_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|win) begin
          state_d    = S_SHOW;
          hold_cnt_d = '0;
          // Scanning downward leaves the lowest set index as the winner.
          for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if ((win & (NUM_PLAYERS'(1) << i)) != '0) winner_id_d = ID_W'(i);
          end
        end
      end
      S_SHOW: begin
        if (ack) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (HOLD_TICKS > 0 && hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
          else hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_SHOW);
  end

`ifdef WINNER_BANNER_BLINK_EN
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    if (state_q == S_IDLE) begin
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (state_d == S_SHOW && tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d     = ~phase_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= S_IDLE;
      winner_id_q <= '0;
      hold_cnt_q  <= '0;
      active_q    <= 1'b0;
`ifdef WINNER_BANNER_BLINK_EN
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      winner_id_q <= winner_id_d;
      hold_cnt_q  <= hold_cnt_d;
      active_q    <= active_d;
`ifdef WINNER_BANNER_BLINK_EN
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  always_comb begin
    glyph_row = make_glyph(winner_id_q);
`ifdef WINNER_BANNER_BLINK_EN
    show_px   = (state_q == S_SHOW) && phase_q;
`else
    show_px   = (state_q == S_SHOW);
`endif
    grn_row   = show_px ? glyph_row : '0;
    red_row   = (show_px && winner_id_q[0]) ? glyph_row : '0;
  end

  assign GrnPixels = {ROWS{grn_row}};
  assign RedPixels = {ROWS{red_row}};
  assign active    = active_q;
  assign winner_id = winner_id_q;

endmodule

// File: tb/tb_winner_banner.sv
// Directed bench for winner_banner: default, short/zero hold, 4-player and blink configurations.
module tb_winner_banner;

  localparam logic [255:0] G0180 = {16{16'h0180}};
  localparam logic [255:0] G0660 = {16{16'h0660}};
  localparam logic [255:0] G6666 = {16{16'h6666}};
  localparam logic [255:0] G1998 = {16{16'h1998}};
  localparam logic [255:0] ZERO  = '0;

  logic clk = 1'b0;
  logic reset, tick;

  logic [1:0] win_a, win_h3, win_h0, win_b;
  logic [3:0] win_p4;
  logic ack_a, ack_h3, ack_h0, ack_b, ack_p4;
  logic [15:0][15:0] red_a, grn_a, red_h3, grn_h3, red_h0, grn_h0, red_b, grn_b, red_p4, grn_p4;
  logic act_a, act_h3, act_h0, act_b, act_p4;
  logic [0:0] id_a, id_h3, id_h0, id_b;
  logic [1:0] id_p4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  winner_banner dut_a (.clk(clk), .reset(reset), .tick(tick), .win(win_a), .ack(ack_a),
    .RedPixels(red_a), .GrnPixels(grn_a), .active(act_a), .winner_id(id_a));
  winner_banner #(.HOLD_TICKS(3)) dut_h3 (.clk(clk), .reset(reset), .tick(tick), .win(win_h3),
    .ack(ack_h3), .RedPixels(red_h3), .GrnPixels(grn_h3), .active(act_h3), .winner_id(id_h3));
  winner_banner #(.HOLD_TICKS(0)) dut_h0 (.clk(clk), .reset(reset), .tick(tick), .win(win_h0),
    .ack(ack_h0), .RedPixels(red_h0), .GrnPixels(grn_h0), .active(act_h0), .winner_id(id_h0));
  winner_banner #(.BLINK_TICKS(2)) dut_b (.clk(clk), .reset(reset), .tick(tick), .win(win_b),
    .ack(ack_b), .RedPixels(red_b), .GrnPixels(grn_b), .active(act_b), .winner_id(id_b));
  winner_banner #(.NUM_PLAYERS(4)) dut_p4 (.clk(clk), .reset(reset), .tick(tick), .win(win_p4),
    .ack(ack_p4), .RedPixels(red_p4), .GrnPixels(grn_p4), .active(act_p4), .winner_id(id_p4));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    win_a = 2'b01; win_h3 = '0; win_h0 = '0; win_b = '0; win_p4 = '0;
    ack_a = 1'b0; ack_h3 = 1'b0; ack_h0 = 1'b0; ack_b = 1'b0; ack_p4 = 1'b0;

    // Reset held with win asserted: screen stays dark.
    for (int c = 0; c < 4; c++) begin
      step(1);
      check("rst_active", 256'(act_a), 256'(1'b0));
      check("rst_grn", grn_a, ZERO);
      check("rst_red", red_a, ZERO);
    end
    reset = 1'b0;
    step(1);
    check("p0_active", 256'(act_a), 256'(1'b1));
    check("p0_id", 256'(id_a), 256'(1'b0));
    check("p0_grn", grn_a, G0180);
    check("p0_red", red_a, ZERO);
    win_a = 2'b00;

    // Simultaneous wins resolve to the lowest index; later wins ignored in SHOW.
    ack_a = 1'b1; step(1); ack_a = 1'b0;
    check("ack_clear", 256'(act_a), 256'(1'b0));
    win_a = 2'b11; step(1); win_a = 2'b00;
    check("tie_id", 256'(id_a), 256'(1'b0));
    check("tie_grn", grn_a, G0180);
    win_a = 2'b10; step(1); win_a = 2'b00;
    check("show_ignore_id", 256'(id_a), 256'(1'b0));
    check("show_ignore_grn", grn_a, G0180);
    ack_a = 1'b1; step(1); ack_a = 1'b0;

    // Player 1 is yellow; ack clears next cycle.
    win_a = 2'b10; step(1); win_a = 2'b00;
    check("p1_id", 256'(id_a), 256'(1'b1));
    check("p1_grn", grn_a, G0660);
    check("p1_red", red_a, G0660);
    ack_a = 1'b1; step(1); ack_a = 1'b0;
    check("p1_ack_active", 256'(act_a), 256'(1'b0));
    check("p1_ack_grn", grn_a, ZERO);
    check("p1_ack_red", red_a, ZERO);

    // ack and win in the same SHOW cycle: return to IDLE, win dropped.
    win_a = 2'b01; step(1);
    win_a = 2'b10; ack_a = 1'b1; step(1);
    check("ackwin_active", 256'(act_a), 256'(1'b0));
    win_a = 2'b00; ack_a = 1'b0; step(2);
    check("ackwin_nolatch", 256'(act_a), 256'(1'b0));
    check("ackwin_grn", grn_a, ZERO);
    ack_a = 1'b1; step(1); ack_a = 1'b0;
    check("ack_idle", 256'(act_a), 256'(1'b0));

    // Reset during SHOW clears winner_id and the screen.
    win_a = 2'b10; step(1); win_a = 2'b00;
    check("pre_rst_id", 256'(id_a), 256'(1'b1));
    reset = 1'b1; step(1); reset = 1'b0;
    check("midrst_active", 256'(act_a), 256'(1'b0));
    check("midrst_id", 256'(id_a), 256'(1'b0));
    check("midrst_red", red_a, ZERO);

    // HOLD_TICKS=3: cleared on the third tick.
    win_h3 = 2'b01; step(1); win_h3 = 2'b00;
    check("h3_start", 256'(act_h3), 256'(1'b1));
    tick_pulse(); check("h3_t1", 256'(act_h3), 256'(1'b1)); step(3);
    tick_pulse(); check("h3_t2", 256'(act_h3), 256'(1'b1)); step(3);
    tick_pulse(); check("h3_t3", 256'(act_h3), 256'(1'b0));
    check("h3_t3_grn", grn_h3, ZERO);
    step(3);

    // HOLD_TICKS=0: held indefinitely.
    win_h0 = 2'b01; step(1); win_h0 = 2'b00;
    for (int t = 0; t < 1000; t++) begin
      tick_pulse(); step(3);
    end
    check("h0_active", 256'(act_h0), 256'(1'b1));
    check("h0_grn", grn_h0, G0180);

    // 4 players: id3 yellow, id2 green, tie of 2 and 3 picks 2.
    win_p4 = 4'b1000; step(1); win_p4 = 4'b0000;
    check("p4_id3", 256'(id_p4), 256'(2'd3));
    check("p4_id3_grn", grn_p4, G6666);
    check("p4_id3_red", red_p4, G6666);
    ack_p4 = 1'b1; step(1); ack_p4 = 1'b0;
    win_p4 = 4'b1100; step(1); win_p4 = 4'b0000;
    check("p4_id2", 256'(id_p4), 256'(2'd2));
    check("p4_id2_grn", grn_p4, G1998);
    check("p4_id2_red", red_p4, ZERO);

    // Blink configuration with BLINK_TICKS=2.
    win_b = 2'b01; step(1); win_b = 2'b00;
    check("blink_start", grn_b, G0180);
    for (int t = 1; t <= 6; t++) begin
      logic [255:0] exp_px;
      tick_pulse();
`ifdef WINNER_BANNER_BLINK_EN
      exp_px = (t == 2 || t == 3 || t == 6) ? ZERO : G0180;
`else
      exp_px = G0180;
`endif
      check($sformatf("blink_t%0d_grn", t), grn_b, exp_px);
      check($sformatf("blink_t%0d_active", t), 256'(act_b), 256'(1'b1));
      step(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
